// File: rtl/avr109_pkg.sv
// Shared types and constants for the AVR109 UART receive path.
// Also provides the divider calculation reused by the transmit side.
package avr109_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_MID = 8;

    // Clocks per oversample tick, floored and never allowed below one.
    function automatic int calc_div(input int clk_freq, input int baud_rate);
        int d;
        d = clk_freq / (baud_rate * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/avr109_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick on the wrap.
// A synchronous clear restarts the count so a bit period aligns to a start edge.
module avr109_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/avr109_uart_rx.sv
// 16x oversampling 8N1 receiver producing single-cycle byte and framing-error pulses.
// Define AVR109_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote of sub-bits 7, 8, 9.
module avr109_uart_rx
    import avr109_pkg::*;
#(
    parameter int CLK_FREQUENCY = 1560000,
    parameter int BAUD_RATE     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rx_enabled,
    output logic [7:0] rx_data,
    output logic       rx_avail,
    output logic       frame_err
);

    localparam int DIV = calc_div(CLK_FREQUENCY, BAUD_RATE);
    localparam logic [3:0] SUB_LAST = 4'(OVERSAMPLE - 1);

    rx_state_e  state_q, state_d;
    logic       sync1_q, sync2_q, prev_q;
    logic [3:0] sub_q, sub_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_avail_q, rx_avail_d;
    logic       frame_err_q, frame_err_d;

    logic rxd_s;
    logic fall;
    logic tick;
    logic div_clr;
    logic bit_val;
    logic sample_now;
    logic sub_wrap;
    logic abort;

    assign rxd_s = sync2_q;
    assign fall  = prev_q & ~sync2_q;

    avr109_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (div_clr),
        .tick (tick)
    );

`ifdef AVR109_RX_MAJORITY_EN
    // Decision lands on the tick of sub-bit 9, once sub-bits 7 and 8 are held.
    localparam logic [3:0] DECIDE_SUB = 4'(SAMPLE_MID);

    logic s7_q, s7_d, s8_q, s8_d;

    always_comb begin
        s7_d = s7_q;
        s8_d = s8_q;
        if (tick && (sub_q == 4'(SAMPLE_MID - 2))) s7_d = rxd_s;
        if (tick && (sub_q == 4'(SAMPLE_MID - 1))) s8_d = rxd_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s7_q <= 1'b1;
            s8_q <= 1'b1;
        end else begin
            s7_q <= s7_d;
            s8_q <= s8_d;
        end
    end

    assign bit_val = (s7_q & s8_q) | (s7_q & rxd_s) | (s8_q & rxd_s);
`else
    localparam logic [3:0] DECIDE_SUB = 4'(SAMPLE_MID - 1);

    assign bit_val = rxd_s;
`endif

    assign sample_now = tick && (sub_q == DECIDE_SUB);
    assign sub_wrap   = tick && (sub_q == SUB_LAST);
    assign abort      = (state_q != IDLE) && !rx_enabled;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:      if (rx_enabled && fall) state_d = START;
                START: begin
                    if (sample_now && bit_val) state_d = IDLE;
                    else if (sub_wrap)         state_d = DATA;
                end
                DATA:      if (sub_wrap && (bit_idx_q == 3'd7)) state_d = STOP;
                STOP:      if (sample_now) state_d = bit_val ? IDLE : WAIT_HIGH;
                WAIT_HIGH: if (rxd_s) state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Output and datapath logic
    always_comb begin
        div_clr     = 1'b0;
        sub_d       = sub_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_avail_d  = 1'b0;
        frame_err_d = 1'b0;
        if (!abort) begin
            case (state_q)
                IDLE: begin
                    if (rx_enabled && fall) begin
                        div_clr   = 1'b1;
                        sub_d     = '0;
                        bit_idx_d = '0;
                    end
                end
                START: begin
                    if (tick) sub_d = sub_q + 4'd1;
                end
                DATA: begin
                    if (tick) sub_d = sub_q + 4'd1;
                    if (sample_now) shift_d = {bit_val, shift_q[7:1]};
                    if (sub_wrap) bit_idx_d = bit_idx_q + 3'd1;
                end
                STOP: begin
                    if (tick) sub_d = sub_q + 4'd1;
                    if (sample_now) begin
                        if (bit_val) begin
                            rx_data_d  = shift_q;
                            rx_avail_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            sub_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_avail_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= rxd;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            sub_q       <= sub_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_avail_q  <= rx_avail_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_avail  = rx_avail_q;
    assign frame_err = frame_err_q;

endmodule
